dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_array.sv | 35 +++
 rtl/dmem_ctrl.sv | 133 +++++++++++++
 tb/tb_dmem_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller and its storage array.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LANES  = WORD_W / BYTE_W;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Accepted transaction, minus the word index whose width depends on depth
  typedef struct packed {
    logic              is_store;
    logic              oor;
    logic [WORD_W-1:0] data;
    logic [LANES-1:0]  be;
  } req_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: one byte-enabled write port and one registered read port
// whose output can be cleared (reset or out-of-range load).
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [LANES-1:0]  wbe,
  input  logic              re,
  input  logic              rclr,
  input  logic [IDX_W-1:0]  raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(LANES); b++) begin
        if (wbe[b]) mem[waddr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rclr)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts one load or store at a time, waits WAIT_STATES
// cycles, then commits/reads the array and pulses the matching valid.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dmem_read_ready,
  input  logic [ADDR_W-1:0] dmem_read_address,
  output logic              dmem_read_valid,
  output logic [WORD_W-1:0] dmem_read_data,
  input  logic              dmem_write_ready,
  input  logic [ADDR_W-1:0] dmem_write_address,
  input  logic [WORD_W-1:0] dmem_write_data,
  input  logic [LANES-1:0]  dmem_write_byte,
  output logic              dmem_write_valid,
  output logic              dmem_fault
);

  localparam int unsigned       IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);
  localparam bit                NO_WAIT   = (WAIT_STATES == 0);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  req_t              cap_req;
  logic [IDX_W-1:0]  cap_idx;

  logic [ADDR_W-1:0] sel_addr_c;
  req_t              in_req_c;
  logic [IDX_W-1:0]  in_idx_c;
  req_t              cm_req_c;
  logic [IDX_W-1:0]  cm_idx_c;
  logic              accept_c;
  logic              commit_c;
  logic              arr_we_c;
  logic              arr_re_c;
  logic              arr_clr_c;
  logic              unused_addr_lsb;

  // Store wins when both requests are up; the load is taken on the next IDLE cycle
  always_comb begin
    sel_addr_c        = dmem_write_ready ? dmem_write_address : dmem_read_address;
    in_req_c.is_store = dmem_write_ready;
    in_req_c.oor      = |sel_addr_c[ADDR_W-1:IDX_W+2];
    in_req_c.data     = dmem_write_data;
    in_req_c.be       = dmem_write_byte;
    in_idx_c          = sel_addr_c[IDX_W+1:2];
  end

  assign unused_addr_lsb = ^sel_addr_c[1:0];
  assign accept_c        = (state == ST_IDLE) && (dmem_write_ready || dmem_read_ready);

  // Commit on the edge entering RESP; with no wait states that is the accepting edge itself
  always_comb begin
    commit_c = 1'b0;
    cm_req_c = cap_req;
    cm_idx_c = cap_idx;
    if (NO_WAIT && accept_c) begin
      commit_c = 1'b1;
      cm_req_c = in_req_c;
      cm_idx_c = in_idx_c;
    end else if (state == ST_WAIT && wait_cnt == WAIT_W'(1)) begin
      commit_c = 1'b1;
    end
  end

  assign arr_we_c  = reset && commit_c && cm_req_c.is_store && !cm_req_c.oor;
  assign arr_re_c  = reset && commit_c && !cm_req_c.is_store;
  assign arr_clr_c = !reset || (arr_re_c && cm_req_c.oor);

  always_ff @(posedge clk) begin
    if (accept_c) begin
      cap_req <= in_req_c;
      cap_idx <= in_idx_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= ST_IDLE;
      wait_cnt         <= '0;
      dmem_read_valid  <= 1'b0;
      dmem_write_valid <= 1'b0;
      dmem_fault       <= 1'b0;
    end else begin
      dmem_read_valid  <= commit_c && !cm_req_c.is_store;
      dmem_write_valid <= commit_c && cm_req_c.is_store;
      dmem_fault       <= commit_c && cm_req_c.oor;
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            if (NO_WAIT) begin
              state <= ST_RESP;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_W'(1)) begin
            state    <= ST_RESP;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (arr_we_c),
    .waddr(cm_idx_c),
    .wdata(cm_req_c.data),
    .wbe  (cm_req_c.be),
    .re   (arr_re_c),
    .rclr (arr_clr_c),
    .raddr(cm_idx_c),
    .rdata(dmem_read_data)
  );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: three instances (1, 3 and 0 wait states) checked every cycle
// against a transaction-level model, plus literal expectations for directed cases.
module tb_dmem_ctrl;

  localparam int NI = 3;

  function automatic int ws_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 0);
  endfunction

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rr [NI];
  logic        wr [NI];
  logic [31:0] ra [NI];
  logic [31:0] wa [NI];
  logic [31:0] wd [NI];
  logic [3:0]  wb [NI];
  logic        rv [NI];
  logic        wv [NI];
  logic        flt[NI];
  logic [31:0] rd [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(ws_of(g))) u_dut (
      .clk               (clk),
      .reset             (reset),
      .dmem_read_ready   (rr[g]),
      .dmem_read_address (ra[g]),
      .dmem_read_valid   (rv[g]),
      .dmem_read_data    (rd[g]),
      .dmem_write_ready  (wr[g]),
      .dmem_write_address(wa[g]),
      .dmem_write_data   (wd[g]),
      .dmem_write_byte   (wb[g]),
      .dmem_write_valid  (wv[g]),
      .dmem_fault        (flt[g])
    );
  end

  typedef struct {
    int          inst;
    int          due;
    bit          is_load;
    bit          fault;
    logic [31:0] data;
  } ev_t;

  ev_t         evq[$];
  logic [31:0] mdl_mem[NI][1024];
  logic [31:0] exp_rd [NI];
  int          cyc = 0;
  bit          rst_edge = 1'b0;
  bit          armed = 1'b0;
  int          nerr = 0;
  int          nchk = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  function automatic bit oor(logic [31:0] a);
    return a[31:12] != 20'h0;
  endfunction

  function automatic void mdl_store(int i, logic [31:0] a, logic [31:0] d, logic [3:0] be);
    if (oor(a)) return;
    for (int b = 0; b < 4; b++)
      if (be[b]) mdl_mem[i][a[11:2]][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic logic [31:0] mdl_load(int i, logic [31:0] a);
    return oor(a) ? 32'h0 : mdl_mem[i][a[11:2]];
  endfunction

  function automatic void push_ev(int i, int due, bit is_load, bit fault, logic [31:0] data);
    ev_t e;
    e.inst = i; e.due = due; e.is_load = is_load; e.fault = fault; e.data = data;
    evq.push_back(e);
  endfunction

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= !reset;
  end

  // Every cycle: a scheduled response must appear exactly on its due cycle, nothing otherwise
  always @(negedge clk) begin
    logic e_rv, e_wv, e_f;
    if (rst_edge) begin
      armed = 1'b1;
      evq.delete();
      for (int i = 0; i < NI; i++) exp_rd[i] = 32'h0;
    end
    if (armed) begin
      for (int i = 0; i < NI; i++) begin
        e_rv = 1'b0; e_wv = 1'b0; e_f = 1'b0;
        for (int k = 0; k < evq.size(); k++) begin
          if (evq[k].inst == i && evq[k].due == cyc) begin
            e_f = evq[k].fault;
            if (evq[k].is_load) begin
              e_rv      = 1'b1;
              exp_rd[i] = evq[k].fault ? 32'h0 : evq[k].data;
            end else begin
              e_wv = 1'b1;
            end
            evq.delete(k);
            break;
          end
        end
        check($sformatf("cycle_out_i%0d", i), 64'({rv[i], wv[i], flt[i], rd[i]}),
              64'({e_rv, e_wv, e_f, exp_rd[i]}));
      end
    end
  end

  task automatic do_store(input int i, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input bit hold,
                          output logic got_wv, output logic got_f);
    int due;
    @(negedge clk);
    wr[i] = 1'b1; wa[i] = a; wd[i] = d; wb[i] = be;
    due = cyc + 1 + ws_of(i);
    push_ev(i, due, 1'b0, oor(a), 32'h0);
    mdl_store(i, a, d, be);
    do begin
      @(negedge clk);
      if (!hold) wr[i] = 1'b0;
    end while (cyc < due);
    got_wv = wv[i]; got_f = flt[i];
    wr[i] = 1'b0;
  endtask

  task automatic do_load(input int i, input logic [31:0] a, input bit hold,
                         output logic [31:0] got_rd, output logic got_rv, output logic got_f);
    int due;
    @(negedge clk);
    rr[i] = 1'b1; ra[i] = a;
    due = cyc + 1 + ws_of(i);
    push_ev(i, due, 1'b1, oor(a), mdl_load(i, a));
    do begin
      @(negedge clk);
      if (!hold) rr[i] = 1'b0;
    end while (cyc < due);
    got_rd = rd[i]; got_rv = rv[i]; got_f = flt[i];
    rr[i] = 1'b0;
  endtask

  // Store and load raised together; store is served first, load on the following IDLE cycle
  task automatic do_both(input int i, input logic [31:0] sa, input logic [31:0] sd,
                         input logic [31:0] la, output logic [1:0] st_wr,
                         output logic [1:0] ld_wr, output logic [31:0] ld_rd);
    int s_due, l_due;
    @(negedge clk);
    wr[i] = 1'b1; wa[i] = sa; wd[i] = sd; wb[i] = 4'hF;
    rr[i] = 1'b1; ra[i] = la;
    s_due = cyc + 1 + ws_of(i);
    l_due = s_due + 2 + ws_of(i);
    push_ev(i, s_due, 1'b0, oor(sa), 32'h0);
    mdl_store(i, sa, sd, 4'hF);
    push_ev(i, l_due, 1'b1, oor(la), mdl_load(i, la));
    while (cyc < s_due) @(negedge clk);
    st_wr = {wv[i], rv[i]};
    wr[i] = 1'b0;
    while (cyc < l_due) @(negedge clk);
    ld_wr = {wv[i], rv[i]};
    ld_rd = rd[i];
    rr[i] = 1'b0;
  endtask

  // Store accepted, reset asserted during the second wait cycle so the commit never happens
  task automatic do_abort(input int i, input logic [31:0] a, input logic [31:0] d,
                          output logic [34:0] after_rst);
    int t0;
    @(negedge clk);
    wr[i] = 1'b1; wa[i] = a; wd[i] = d; wb[i] = 4'hF;
    t0 = cyc;
    while (cyc < t0 + 2) @(negedge clk);
    reset = 1'b0;
    wr[i] = 1'b0;
    @(negedge clk);
    after_rst = {rv[i], wv[i], flt[i], rd[i]};
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        v, f;
    logic [1:0]  p1, p2;
    logic [34:0] snap;
    logic [31:0] pre [4];
    int          t_last;
    pre[0] = 32'h0102_0304; pre[1] = 32'hA0B0_C0D0;
    pre[2] = 32'hFFFF_0000; pre[3] = 32'h1357_9BDF;
    for (int i = 0; i < NI; i++) begin
      rr[i] = 1'b0; wr[i] = 1'b0; ra[i] = '0; wa[i] = '0; wd[i] = '0; wb[i] = '0;
    end

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({rv[0], wv[0], flt[0], rd[0]}), 64'h0);
    reset = 1'b1;

    do_store(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, v, f);
    check("st_deadbeef_wv", 64'({v, f}), 64'b10);
    do_load(0, 32'h10, 1'b1, r, v, f);
    check("ld_deadbeef", 64'({v, f, r}), 64'({2'b10, 32'hDEAD_BEEF}));

    do_store(0, 32'h20, 32'h1122_3344, 4'hF, 1'b1, v, f);
    do_store(0, 32'h21, 32'h0000_AA00, 4'b0010, 1'b1, v, f);
    do_load(0, 32'h20, 1'b1, r, v, f);
    check("ld_lane_merge", 64'(r), 64'h1122_AA44);

    do_both(0, 32'h8, 32'h55, 32'h8, p1, p2, r);
    check("both_store_phase", 64'(p1), 64'b10);
    check("both_load_phase", 64'(p2), 64'b01);
    check("both_load_data", 64'(r), 64'h0000_0055);

    do_store(0, 32'h0, 32'hCAFE_F00D, 4'hF, 1'b1, v, f);
    do_load(0, 32'h1000, 1'b1, r, v, f);
    check("oor_load", 64'({v, f, r}), 64'({2'b11, 32'h0}));
    do_store(0, 32'h1000, 32'h1234_5678, 4'hF, 1'b1, v, f);
    check("oor_store", 64'({v, f}), 64'b11);
    do_load(0, 32'h0, 1'b1, r, v, f);
    check("word0_intact", 64'({v, f, r}), 64'({2'b10, 32'hCAFE_F00D}));

    do_store(1, 32'h40, 32'hA5A5_A5A5, 4'hF, 1'b0, v, f);
    check("short_store_ws3", 64'(v), 64'h1);
    do_abort(1, 32'h40, 32'hFFFF_FFFF, snap);
    check("abort_outputs", 64'(snap), 64'h0);
    do_load(1, 32'h40, 1'b0, r, v, f);
    check("abort_word_intact", 64'({v, r}), 64'({1'b1, 32'hA5A5_A5A5}));
    do_store(1, 32'h40, 32'h0000_0000, 4'b0000, 1'b1, v, f);
    check("be0_store_valid", 64'({v, f}), 64'b10);
    do_load(1, 32'h43, 1'b1, r, v, f);
    check("be0_word_intact", 64'(r), 64'hA5A5_A5A5);

    for (int k = 0; k < 4; k++) do_store(2, 32'(4 * k), pre[k], 4'hF, 1'b1, v, f);
    t_last = 0;
    for (int k = 0; k < 4; k++) begin
      do_load(2, 32'(4 * k), 1'b1, r, v, f);
      check($sformatf("ws0_load_%0d", k), 64'({v, r}), 64'({1'b1, pre[k]}));
      if (k > 0) check($sformatf("ws0_spacing_%0d", k), 64'(cyc - t_last), 64'd2);
      t_last = cyc;
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
